// File: rtl/cmac_tx_stream_arbiter.sv
// Packet-granular round-robin merge of NUM_CH AXI4-Stream TX channels onto the CMAC TX stream,
// through one output register slice, with saturating per-channel forwarded-packet counters.

module cmac_tx_pkt_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);
  // clear has priority; counter sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + CNT_WIDTH'(1);
  end
endmodule

module cmac_tx_stream_arbiter #(
  parameter  int NUM_CH      = 4,
  parameter  int TDATA_WIDTH = 512,
  parameter  int CNT_WIDTH   = 32,
  localparam int KEEP_WIDTH  = TDATA_WIDTH / 8,
  localparam int GW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [NUM_CH-1:0]             s_axis_tx_tvalid,
  output logic [NUM_CH-1:0]             s_axis_tx_tready,
  input  logic [NUM_CH*TDATA_WIDTH-1:0] s_axis_tx_tdata,
  input  logic [NUM_CH*KEEP_WIDTH-1:0]  s_axis_tx_tkeep,
  input  logic [NUM_CH-1:0]             s_axis_tx_tlast,
  output logic                          axis_net_tx_tvalid,
  input  logic                          axis_net_tx_tready,
  output logic [TDATA_WIDTH-1:0]        axis_net_tx_tdata,
  output logic [KEEP_WIDTH-1:0]         axis_net_tx_tkeep,
  output logic                          axis_net_tx_tlast,
  output logic [GW-1:0]                 grant_ch,
  input  logic                          pkt_cnt_clr,
  output logic [NUM_CH*CNT_WIDTH-1:0]   pkt_cnt
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_nxt;
  logic [GW-1:0]          grant_q, cand, idx, sel;
  logic                   cand_found, slot_free, accept, sel_last;
  logic [NUM_CH-1:0]      ready;
  logic [TDATA_WIDTH-1:0] ch_data [NUM_CH];
  logic [KEEP_WIDTH-1:0]  ch_keep [NUM_CH];

  assign slot_free        = !axis_net_tx_tvalid || axis_net_tx_tready;
  assign s_axis_tx_tready = ready;
  assign grant_ch         = grant_q;

  // Walk offsets high to low so the nearest valid channel after grant_q wins.
  always_comb begin
    cand_found = 1'b0;
    cand       = grant_q;
    idx        = '0;
    for (int off = NUM_CH; off >= 1; off--) begin
      idx = GW'((int'(grant_q) + off) % NUM_CH);
      if (s_axis_tx_tvalid[idx]) begin
        cand_found = 1'b1;
        cand       = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sel       = grant_q;
    ready     = '0;
    // tready must fall together with the asynchronous reset, not a cycle later
    if (ap_rst_n) begin
      case (state)
        IDLE: if (cand_found && slot_free) begin
          sel        = cand;
          ready[cand] = 1'b1;
        end
        BUSY:    ready[grant_q] = slot_free;
        default: ;
      endcase
    end
    accept   = |(s_axis_tx_tvalid & ready);
    sel_last = s_axis_tx_tlast[sel];
    if (accept) state_nxt = sel_last ? IDLE : BUSY;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state   <= IDLE;
      grant_q <= GW'(NUM_CH - 1);
    end else begin
      state <= state_nxt;
      if (accept) grant_q <= sel;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      axis_net_tx_tvalid <= 1'b0;
      axis_net_tx_tdata  <= '0;
      axis_net_tx_tkeep  <= '0;
      axis_net_tx_tlast  <= 1'b0;
    end else if (accept) begin
      axis_net_tx_tvalid <= 1'b1;
      axis_net_tx_tdata  <= ch_data[sel];
      axis_net_tx_tkeep  <= ch_keep[sel];
      axis_net_tx_tlast  <= sel_last;
    end else if (slot_free) begin
      axis_net_tx_tvalid <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_data[i] = s_axis_tx_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
    assign ch_keep[i] = s_axis_tx_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];

    cmac_tx_pkt_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk   (ap_clk),
      .rst_n (ap_rst_n),
      .clr   (pkt_cnt_clr),
      .inc   (accept && sel_last && (sel == GW'(i))),
      .cnt   (pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end
endmodule
